regfile_sb: RTL

- Parametrised general-purpose register file for the pipelined MIPS core, generalised in data width, depth and read-port count.
- Adds a second write port, serving the ALU/load writeback and the mult/div unit.
- Per-register pending scoreboard: producers mark their destination busy at issue, and the marking clears at writeback. Readers get a per-port ready flag for stall logic.
- Same-cycle write-to-read bypass and simulation write trace are retained.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_sb_if.sv | 30 +++
 rtl/rf_read_port.sv | 42 ++++
 rtl/regfile_sb.sv | 90 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the scoreboarded register file
package regfile_pkg;
  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 5;
  localparam int NRD_DEF = 2;

  localparam int WP_ALU = 0;
  localparam int WP_MD  = 1;

  localparam string TRACE_FMT = "%d@%h: $%d <= %h";
endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/write/issue bundle between core and register file
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_ready;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*DW-1:0]   wr_data;
  logic [2*32-1:0]   wr_pc;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic [2**AW-1:0]  pending;
  logic              err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_pc, issue_en, issue_addr,
    input  rd_data, rd_ready, pending, err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, issue_en, issue_addr,
    output rd_data, rd_ready, pending, err
  );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port: zero register, two-way bypass, ready
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            reset,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_word,
  input  logic            i_pend,
  input  logic [1:0]      i_wr_en,
  input  logic [2*AW-1:0] i_wr_addr,
  input  logic [2*DW-1:0] i_wr_data,
  output logic [DW-1:0]   o_data,
  output logic            o_ready
);
  logic w_zero;
  logic w_hit_alu;
  logic w_hit_md;

  assign w_zero    = (i_addr == '0);
  assign w_hit_md  = !reset && i_wr_en[WP_MD]  && (i_wr_addr[WP_MD*AW +: AW]  == i_addr);
  assign w_hit_alu = !reset && i_wr_en[WP_ALU] && (i_wr_addr[WP_ALU*AW +: AW] == i_addr);

  always_comb begin
    o_data  = i_word;
    o_ready = ~i_pend;
    if (w_zero) begin
      o_data  = '0;
      o_ready = 1'b1;
    end else if (w_hit_md) begin
      o_data  = i_wr_data[WP_MD*DW +: DW];
      o_ready = 1'b1;
    end else if (w_hit_alu) begin
      o_data  = i_wr_data[WP_ALU*DW +: DW];
      o_ready = 1'b1;
    end
    // Nothing is trustworthy while the array is being cleared.
    if (reset) o_ready = 1'b0;
  end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - dual-write register file with per-register pending scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int TRACE = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic             r_err;

  logic [AW-1:0] w_wa    [2];
  logic [DW-1:0] w_wd    [2];
  logic [1:0]    w_wr_ok;
  logic [1:0]    w_trace;
  logic          w_wb_iss;
  logic          w_iss_ok;

  for (genvar j = 0; j < 2; j++) begin : g_wport
    assign w_wa[j]    = bus.wr_addr[j*AW +: AW];
    assign w_wd[j]    = bus.wr_data[j*DW +: DW];
    assign w_wr_ok[j] = bus.wr_en[j] && (w_wa[j] != '0);
  end

  // A port-0 write shadowed by port 1 to the same register never commits visibly.
  assign w_trace[WP_MD]  = w_wr_ok[WP_MD];
  assign w_trace[WP_ALU] = w_wr_ok[WP_ALU] && !(w_wr_ok[WP_MD] && (w_wa[WP_MD] == w_wa[WP_ALU]));

  assign w_iss_ok = bus.issue_en && (bus.issue_addr != '0);
  assign w_wb_iss = (w_wr_ok[WP_ALU] && (w_wa[WP_ALU] == bus.issue_addr)) ||
                    (w_wr_ok[WP_MD]  && (w_wa[WP_MD]  == bus.issue_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      // Port 1 is applied last so it wins a same-address collision.
      for (int j = 0; j < 2; j++) begin
        if (w_wr_ok[j]) begin
          r_mem[w_wa[j]]  <= w_wd[j];
          r_pend[w_wa[j]] <= 1'b0;
        end
      end
      if (w_iss_ok) begin
        r_pend[bus.issue_addr] <= 1'b1;
        if (r_pend[bus.issue_addr] && !w_wb_iss) r_err <= 1'b1;
      end
    end
  end

  assign bus.pending = {r_pend[DEPTH-1:1], 1'b0};
  assign bus.err     = r_err;

  for (genvar k = 0; k < NRD; k++) begin : g_rport
    logic [AW-1:0] w_ra;
    assign w_ra = bus.rd_addr[k*AW +: AW];

    rf_read_port #(.DW(DW), .AW(AW)) u_rp (
      .reset     (reset),
      .i_addr    (w_ra),
      .i_word    (r_mem[w_ra]),
      .i_pend    (r_pend[w_ra]),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_data    (bus.rd_data[k*DW +: DW]),
      .o_ready   (bus.rd_ready[k])
    );
  end

  if (TRACE != 0) begin : g_trace
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int j = 0; j < 2; j++) begin
          if (w_trace[j]) $display(TRACE_FMT, $time, bus.wr_pc[j*32 +: 32], w_wa[j], w_wd[j]);
        end
      end
    end
  end
endmodule
